bus_fabric: RTL and testbench

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_fabric_pkg.sv | 37 +++
 rtl/bus_fabric_decode.sv | 31 +++
 rtl/bus_fabric.sv | 143 ++++++++++++++
 tb/tb_bus_fabric.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared definitions for the single-master bus fabric.
// Holds the FSM state encoding, the default memory map (IMEM low, DMEM high),
// the latched request payload type and the address-match helper.
package bus_fabric_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned CNT_W  = 8;

  // Default memory map: bit 31 splits IMEM (slave 0) from DMEM (slave 1).
  localparam logic [ADDR_W-1:0] IMEM_BASE = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DMEM_BASE = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] MAP_MASK  = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Request fields held stable toward the slave for the whole transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic [FMT_W-1:0]  fmt;
  } req_t;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_fabric_decode.sv
// Combinational address decoder for bus_fabric.
// Ports:
//   addr   in   ADDR_W   byte address to decode
//   sel_c  out  NUM_SLV  one-hot slave select, lowest matching index wins
//   miss_c out  1        no slave matches the address
module bus_decode
  import bus_fabric_pkg::*;
#(
  parameter int unsigned                NUM_SLV  = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE = {DMEM_BASE, IMEM_BASE},
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_MASK = {MAP_MASK, MAP_MASK}
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel_c,
  output logic               miss_c
);

  // Priority scan: once a match is found, higher indices are masked off.
  always_comb begin
    sel_c  = '0;
    miss_c = 1'b1;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (miss_c && addr_hit(addr, SLV_BASE[k*ADDR_W +: ADDR_W],
                             SLV_MASK[k*ADDR_W +: ADDR_W])) begin
        sel_c[k] = 1'b1;
        miss_c   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, NUM_SLV-slave bus fabric with one outstanding transaction.
// Decodes the request address, forwards the latched request to one slave,
// waits for its response (bounded by TIMEOUT) and returns a one-cycle response.
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_req_* / o_req_ready        master request channel
//   o_rsp_valid/r_data/err       master response pulse
//   o_slv_valid, i_slv_ready     per-slave request handshake (one-hot)
//   o_slv_addr/w_data/w_en/fmt   latched request fields shared by all slaves
//   i_slv_rsp_valid, i_slv_r_data per-slave response
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int unsigned               NUM_SLV  = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {DMEM_BASE, IMEM_BASE},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {MAP_MASK, MAP_MASK},
  parameter int unsigned               TIMEOUT  = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [ADDR_W-1:0]         i_req_addr,
  input  logic                      i_req_w_en,
  input  logic [DATA_W-1:0]         i_req_w_data,
  input  logic [FMT_W-1:0]          i_req_fmt,
  output logic                      o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_r_data,
  output logic                      o_rsp_err,
  output logic [NUM_SLV-1:0]        o_slv_valid,
  input  logic [NUM_SLV-1:0]        i_slv_ready,
  output logic [ADDR_W-1:0]         o_slv_addr,
  output logic [DATA_W-1:0]         o_slv_w_data,
  output logic                      o_slv_w_en,
  output logic [FMT_W-1:0]          o_slv_fmt,
  input  logic [NUM_SLV-1:0]        i_slv_rsp_valid,
  input  logic [NUM_SLV*DATA_W-1:0] i_slv_r_data
);

  state_t             state;
  req_t               req_q;
  logic [NUM_SLV-1:0] sel_q;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_SLV-1:0] dec_sel_c;
  logic               dec_miss_c;
  logic               slv_ready_c;
  logic               slv_rsp_c;
  logic [DATA_W-1:0]  slv_r_data_c;
  logic               last_c;

  bus_decode #(
    .NUM_SLV  (NUM_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr   (i_req_addr),
    .sel_c  (dec_sel_c),
    .miss_c (dec_miss_c)
  );

  // Only the latched slave's handshake and read data are observed.
  always_comb begin
    slv_ready_c  = |(i_slv_ready & sel_q);
    slv_rsp_c    = |(i_slv_rsp_valid & sel_q);
    slv_r_data_c = '0;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (sel_q[k]) slv_r_data_c = slv_r_data_c | i_slv_r_data[k*DATA_W +: DATA_W];
    end
  end

  // Last permitted REQ/WAIT cycle; counter starts at 0 on the first REQ cycle.
  assign last_c = (cnt == CNT_W'(TIMEOUT - 1));

  assign o_slv_addr   = req_q.addr;
  assign o_slv_w_data = req_q.w_data;
  assign o_slv_w_en   = req_q.w_en;
  assign o_slv_fmt    = req_q.fmt;

  // Transaction FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      o_req_ready  <= 1'b1;
      req_q        <= '0;
      sel_q        <= '0;
      cnt          <= '0;
      o_slv_valid  <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_err    <= 1'b0;
      o_rsp_r_data <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            req_q       <= '{addr: i_req_addr, w_en: i_req_w_en,
                             w_data: i_req_w_data, fmt: i_req_fmt};
            sel_q       <= dec_sel_c;
            cnt         <= '0;
            o_req_ready <= 1'b0;
            if (dec_miss_c) begin
              state       <= ST_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
            end else begin
              state       <= ST_REQ;
              o_slv_valid <= dec_sel_c;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          // A response in REQ only counts together with the slave's ready.
          if (slv_rsp_c && (slv_ready_c || state == ST_WAIT)) begin
            state        <= ST_RESP;
            o_slv_valid  <= '0;
            o_rsp_valid  <= 1'b1;
            o_rsp_r_data <= req_q.w_en ? '0 : slv_r_data_c;
          end else if (last_c) begin
            state       <= ST_RESP;
            o_slv_valid <= '0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == ST_REQ && slv_ready_c) begin
              state       <= ST_WAIT;
              o_slv_valid <= '0;
            end
          end
        end
        ST_RESP: begin
          state        <= ST_IDLE;
          o_req_ready  <= 1'b1;
          o_rsp_err    <= 1'b0;
          o_rsp_r_data <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric. dut0 uses the default map with TIMEOUT=4;
// dut1 maps both slaves to base 0x80000000 / mask 0xC0000000 (overlap + hole).
// Stimulus pushes the expected response; a monitor pops on every o_rsp_valid.
module tb_bus_fabric;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic        req_valid     [2];
  logic        req_ready     [2];
  logic [31:0] req_addr      [2];
  logic        req_w_en      [2];
  logic [31:0] req_w_data    [2];
  logic [2:0]  req_fmt       [2];
  logic        rsp_valid     [2];
  logic [31:0] rsp_r_data    [2];
  logic        rsp_err       [2];
  logic [1:0]  slv_valid     [2];
  logic [1:0]  slv_ready     [2];
  logic [31:0] slv_addr      [2];
  logic [31:0] slv_w_data    [2];
  logic        slv_w_en      [2];
  logic [2:0]  slv_fmt       [2];
  logic [1:0]  slv_rsp_valid [2];
  logic [63:0] slv_r_data    [2];

  bus_fabric #(.NUM_SLV(2), .TIMEOUT(4)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_addr(req_addr[0]), .i_req_w_en(req_w_en[0]),
    .i_req_w_data(req_w_data[0]), .i_req_fmt(req_fmt[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_r_data(rsp_r_data[0]), .o_rsp_err(rsp_err[0]),
    .o_slv_valid(slv_valid[0]), .i_slv_ready(slv_ready[0]),
    .o_slv_addr(slv_addr[0]), .o_slv_w_data(slv_w_data[0]),
    .o_slv_w_en(slv_w_en[0]), .o_slv_fmt(slv_fmt[0]),
    .i_slv_rsp_valid(slv_rsp_valid[0]), .i_slv_r_data(slv_r_data[0])
  );

  bus_fabric #(
    .NUM_SLV(2),
    .SLV_BASE({32'h8000_0000, 32'h8000_0000}),
    .SLV_MASK({32'hC000_0000, 32'hC000_0000}),
    .TIMEOUT(15)
  ) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_addr(req_addr[1]), .i_req_w_en(req_w_en[1]),
    .i_req_w_data(req_w_data[1]), .i_req_fmt(req_fmt[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_r_data(rsp_r_data[1]), .o_rsp_err(rsp_err[1]),
    .o_slv_valid(slv_valid[1]), .i_slv_ready(slv_ready[1]),
    .o_slv_addr(slv_addr[1]), .o_slv_w_data(slv_w_data[1]),
    .o_slv_w_en(slv_w_en[1]), .o_slv_fmt(slv_fmt[1]),
    .i_slv_rsp_valid(slv_rsp_valid[1]), .i_slv_r_data(slv_r_data[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic score(input int d, input exp_t e);
    chk($sformatf("rsp_r_data_d%0d", d), 64'(rsp_r_data[d]), 64'(e.data));
    chk($sformatf("rsp_err_d%0d", d), 64'(rsp_err[d]), 64'(e.err));
    chk($sformatf("rsp_latency_d%0d", d), 64'(cyc - e.acc), 64'(e.lat));
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid[0] === 1'b1) begin
      chk("rsp_expected_d0", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        score(0, e);
      end
    end
    if (rsp_valid[1] === 1'b1) begin
      chk("rsp_expected_d1", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        score(1, e);
      end
    end
  end

  // Drive one request for one cycle, called on a negedge while the DUT is idle.
  // Latency is counted from the acceptance cycle.
  task automatic issue(input int d, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [2:0] f, input bit push,
                       input logic [31:0] ed, input logic ee, input int lat);
    exp_t e;
    chk($sformatf("req_ready_idle_d%0d", d), 64'(req_ready[d]), 64'd1);
    req_valid[d]  = 1'b1;
    req_addr[d]   = a;
    req_w_en[d]   = we;
    req_w_data[d] = wd;
    req_fmt[d]    = f;
    if (push) begin
      e.data = ed;
      e.err  = ee;
      e.lat  = lat;
      e.acc  = cyc;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic chk_reset(input int d);
    chk($sformatf("rst_req_ready_d%0d", d), 64'(req_ready[d]), 64'd1);
    chk($sformatf("rst_ctrl_d%0d", d),
        64'({slv_valid[d], rsp_valid[d], rsp_err[d], slv_w_en[d], slv_fmt[d]}), 64'd0);
    chk($sformatf("rst_rsp_r_data_d%0d", d), 64'(rsp_r_data[d]), 64'd0);
    chk($sformatf("rst_slv_addr_d%0d", d), 64'(slv_addr[d]), 64'd0);
    chk($sformatf("rst_slv_w_data_d%0d", d), 64'(slv_w_data[d]), 64'd0);
  endtask

  logic [31:0] t_addr [3];
  logic        t_we   [3];
  logic [31:0] t_wd   [3];
  logic [2:0]  t_fmt  [3];
  logic [31:0] t_rd0  [3];
  logic [31:0] t_exp  [3];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; req_w_en[d] = 1'b0;
      req_w_data[d] = '0; req_fmt[d] = '0;
      slv_ready[d] = '0; slv_rsp_valid[d] = '0; slv_r_data[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    @(negedge clk);

    // Read from DMEM; slave 1 holds ready, responds later; slave 0 noise ignored.
    slv_ready[0] = 2'b10;
    issue(0, 32'h8000_0010, 1'b0, 32'h0, 3'b010, 1'b1, 32'hDEAD_BEEF, 1'b0, 4);
    chk("rd_slv_valid", 64'(slv_valid[0]), 64'h2);
    chk("rd_slv_addr", 64'(slv_addr[0]), 64'h8000_0010);
    @(negedge clk);
    chk("rd_slv_valid_wait", 64'(slv_valid[0]), 64'h0);
    @(negedge clk);
    slv_rsp_valid[0] = 2'b11;
    slv_r_data[0]    = {32'hDEAD_BEEF, 32'hBAD0_BAD0};
    @(negedge clk);
    slv_rsp_valid[0] = 2'b00;
    slv_ready[0]     = 2'b00;
    @(negedge clk);

    // Write to IMEM with same-cycle ready + response; write returns 0 data.
    slv_ready[0]     = 2'b01;
    slv_rsp_valid[0] = 2'b01;
    slv_r_data[0]    = {32'h0, 32'hFFFF_FFFF};
    issue(0, 32'h0000_0004, 1'b1, 32'h1234_5678, 3'b010, 1'b1, 32'h0, 1'b0, 2);
    chk("wr_slv_valid", 64'(slv_valid[0]), 64'h1);
    chk("wr_slv_fields", {slv_addr[0], slv_w_data[0]}, {32'h0000_0004, 32'h1234_5678});
    chk("wr_slv_ctl", 64'({slv_w_en[0], slv_fmt[0]}), 64'({1'b1, 3'b010}));
    @(negedge clk);
    slv_ready[0]     = 2'b00;
    slv_rsp_valid[0] = 2'b00;
    @(negedge clk);

    // Timeout: slave never answers, 4 REQ cycles then error response.
    issue(0, 32'h8000_0020, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0, 1'b1, 5);
    chk("to_slv_valid_req", 64'(slv_valid[0]), 64'h2);
    repeat (3) @(negedge clk);
    chk("to_slv_valid_last", 64'(slv_valid[0]), 64'h2);
    @(negedge clk);
    chk("to_slv_valid_drop", 64'(slv_valid[0]), 64'h0);
    @(negedge clk);
    slv_rsp_valid[0] = 2'b10;
    slv_r_data[0]    = {32'h5555_5555, 32'h0};
    @(negedge clk);
    slv_rsp_valid[0] = 2'b00;
    slv_ready[0]     = 2'b10;
    slv_rsp_valid[0] = 2'b10;
    slv_r_data[0]    = {32'hCAFE_F00D, 32'h0};
    issue(0, 32'h8000_0030, 1'b0, 32'h0, 3'b010, 1'b1, 32'hCAFE_F00D, 1'b0, 2);
    @(negedge clk);
    slv_ready[0]     = 2'b00;
    slv_rsp_valid[0] = 2'b00;
    @(negedge clk);

    // Reset in WAIT abandons the transaction without a response.
    slv_ready[0] = 2'b10;
    issue(0, 32'h8000_0040, 1'b1, 32'hAAAA_5555, 3'b001, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    chk("rw_slv_valid_wait", 64'(slv_valid[0]), 64'h0);
    chk("rw_slv_addr_pre", 64'(slv_addr[0]), 64'h8000_0040);
    #2 rst = 1'b1;
    #1 chk_reset(0);
    #1 rst = 1'b0;
    slv_ready[0] = 2'b00;
    @(negedge clk);
    slv_ready[0]     = 2'b01;
    slv_rsp_valid[0] = 2'b01;
    slv_r_data[0]    = {32'h0, 32'h1357_9BDF};
    issue(0, 32'h0000_0100, 1'b0, 32'h0, 3'b010, 1'b1, 32'h1357_9BDF, 1'b0, 2);
    @(negedge clk);
    slv_ready[0]     = 2'b00;
    slv_rsp_valid[0] = 2'b00;
    @(negedge clk);

    // Unmapped address on dut1: error one cycle after acceptance, no slave valid.
    slv_ready[1]     = 2'b11;
    slv_rsp_valid[1] = 2'b11;
    slv_r_data[1]    = {32'h2222_1111, 32'h1111_0000};
    issue(1, 32'h4000_0000, 1'b0, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, 1);
    chk("miss_slv_valid", 64'(slv_valid[1]), 64'h0);
    @(negedge clk);

    // Overlapping bases: slave 0 always wins; back-to-back transactions.
    t_addr = '{32'h8000_0100, 32'hBFFF_FFFC, 32'h8000_0008};
    t_we   = '{1'b0, 1'b1, 1'b0};
    t_wd   = '{32'h0, 32'hA5A5_A5A5, 32'h0};
    t_fmt  = '{3'b010, 3'b010, 3'b100};
    t_rd0  = '{32'h1111_0000, 32'h7777_7777, 32'h0F0F_0F0F};
    t_exp  = '{32'h1111_0000, 32'h0, 32'h0F0F_0F0F};
    for (int i = 0; i < 3; i++) begin
      slv_r_data[1] = {32'h2222_1111, t_rd0[i]};
      issue(1, t_addr[i], t_we[i], t_wd[i], t_fmt[i], 1'b1, t_exp[i], 1'b0, 2);
      chk($sformatf("ovl_slv_valid_%0d", i), 64'(slv_valid[1]), 64'h1);
      chk($sformatf("ovl_slv_addr_%0d", i), 64'(slv_addr[1]), 64'(t_addr[i]));
      @(negedge clk);
      @(negedge clk);
    end
    slv_ready[1]     = 2'b00;
    slv_rsp_valid[1] = 2'b00;

    repeat (4) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
